spi_bram_ctrl: RTL
==================

Name: spi_bram_ctrl

Overview:
- Command sequencer between the SPI byte-level slave and a single-port block RAM.
- Decodes the byte stream of each SSEL frame into command, address and data phases.
- Issues BRAM read/write cycles with address auto-increment.
- Prefetches read data so the SPI transmitter always has the next MISO byte ready.

Parameters:
- AW, 10, BRAM address width (1..16); address bits above AW-1 are discarded.
- DW, 8, data width; fixed at 8 (one SPI byte per word).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- frame_start  in  1  one-cycle pulse: SSEL falling edge, already synchronised.
- frame_end  in  1  one-cycle pulse: SSEL rising edge.
- rx_valid  in  1  one-cycle pulse: a complete MOSI byte is on rx_byte.
- rx_byte  in  8  received byte, valid with rx_valid.
- tx_req  in  1  one-cycle pulse: SPI layer latches tx_byte this cycle for the next byte slot.
- tx_byte  out  8  byte offered to the SPI transmitter.
- mem_en  out  1  BRAM enable, one-cycle pulse per access.
- mem_we  out  1  BRAM write enable, qualified by mem_en.
- mem_addr  out  AW  BRAM address.
- mem_wdata  out  8  BRAM write data.
- mem_rdata  in  8  BRAM read data, valid 1 cycle after mem_en with mem_we=0.
- busy  out  1  high while a frame is in progress (state != IDLE).
- cmd_err  out  1  sticky illegal-command flag, cleared by frame_start.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; tx_byte, mem_en, mem_we, mem_addr, mem_wdata, busy, cmd_err all 0. Takes effect mid-frame; any pending prefetch is dropped.
- Frame format: CMD, ADDR_H, ADDR_L, then data bytes. Address = {ADDR_H, ADDR_L}[AW-1:0].
- Commands: 0x01 WRITE, 0x02 READ, 0x03 STATUS. Any other value is illegal.
- FSM states: IDLE, CMD, ADDR_H, ADDR_L, WR, RD, IGNORE.
- IDLE -> CMD on frame_start. frame_start also sets tx_byte=0x00 and clears cmd_err.
- CMD, on rx_valid:
  - 0x01/0x02 -> ADDR_H.
  - 0x03 -> IGNORE, with tx_byte = {7'b0, cmd_err}.
  - Illegal -> IGNORE, cmd_err=1, tx_byte=0xFF.
- ADDR_H -> ADDR_L on rx_valid; latch the high byte.
- ADDR_L, on rx_valid: load the address register.
  - WRITE -> WR.
  - READ -> RD, and issue a prefetch read the next cycle.
- WR: each rx_valid writes one word. Next cycle: mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=rx_byte. Then addr increments modulo 2^AW (2^AW-1 wraps to 0).
- RD prefetch: issue mem_en=1, mem_we=0 at addr. Capture mem_rdata into tx_byte 2 cycles after the issue cycle, then addr increments modulo 2^AW.
- RD on tx_req: the current tx_byte is consumed by the SPI layer; a new prefetch starts on the next cycle. rx_valid in RD is ignored (dummy MOSI bytes).
- Prefetch latency: issue to tx_byte update = 3 cycles. The SPI layer guarantees at least 4 clk between rx_valid/tx_req and the following tx_req.
- IGNORE: all rx_valid/tx_req ignored; tx_byte held.
- frame_end in any state -> IDLE, tx_byte=0x00.
  - If rx_valid coincides with frame_end in WR, the write still completes.
  - A prefetch in flight is discarded and does not update tx_byte.
- frame_start while not IDLE (missed frame_end) -> restart in CMD; state is treated as a fresh frame.
- Frame ending before data phase (after CMD or address bytes only): no memory access occurs.
- mem_en is never asserted outside WR/RD. mem_we=1 only in WR.

Test Plan:
- Write burst: frame {01,00,10,AA,BB,CC} -> mem_we pulses at addr 0x010/011/012 with AA/BB/CC; busy falls 1 cycle after frame_end.
- Read back: frame {02,00,10} then 3 tx_req -> tx_byte sequence AA, BB, CC; final addr register 0x013; a 4th prefetch is discarded on frame_end.
- Wrap: WRITE at 0x3FF with bytes 11,22 (AW=10) -> writes at 0x3FF then 0x000. READ at 0x3FF -> tx 11 then 22.
- Illegal command: frame {7E,..} -> cmd_err=1, tx_byte=0xFF, no mem_en. Next frame {03} -> tx_byte=0x01 until a new frame_start clears cmd_err (0x00 on the following STATUS).
- Abort: frame_end after {01,00} -> no mem_en ever. rx_valid and frame_end in the same cycle in WR -> write still occurs.
- Reset mid-read: rst low during RD prefetch -> next cycle mem_en=0, tx_byte=0, busy=0, state IDLE; the next frame behaves normally.

Source files
------------

// File: rtl/spi_bram_ctrl.sv
// SPI command sequencer: decodes CMD/ADDR/DATA byte frames into single-port BRAM accesses
// with address auto-increment and a read prefetch so MISO data is always staged.
module spi_bram_ctrl #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          frame_end,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_byte,
    input  logic          tx_req,
    output logic [DW-1:0] tx_byte,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          cmd_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR_H = 3'd2;
    localparam logic [2:0] S_ADDR_L = 3'd3;
    localparam logic [2:0] S_WR     = 3'd4;
    localparam logic [2:0] S_RD     = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    localparam logic [DW-1:0] CMD_WRITE  = 8'h01;
    localparam logic [DW-1:0] CMD_READ   = 8'h02;
    localparam logic [DW-1:0] CMD_STATUS = 8'h03;

    logic [2:0]    state_q,  state_d;
    logic          cmd_rd_q, cmd_rd_d;
    logic [7:0]    addr_h_q, addr_h_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [DW-1:0] tx_q,     tx_d;
    logic          en_q,     en_d;
    logic          we_q,     we_d;
    logic [AW-1:0] maddr_q,  maddr_d;
    logic [DW-1:0] wdata_q,  wdata_d;
    logic          err_q,    err_d;
    logic          snap_q,   snap_d;
    logic          pf_q,     pf_d;
    logic          rd_p1_q,  rd_p1_d;
    logic          rd_p2_q,  rd_p2_d;

    always_comb begin
        state_d  = state_q;
        cmd_rd_d = cmd_rd_q;
        addr_h_d = addr_h_q;
        addr_d   = addr_q;
        tx_d     = tx_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        snap_d   = snap_q;
        pf_d     = 1'b0;
        rd_p1_d  = 1'b0;
        rd_p2_d  = rd_p1_q;

        // Prefetch pipeline: request -> mem_en -> BRAM latency -> capture into tx_byte
        if (pf_q) begin
            en_d    = 1'b1;
            maddr_d = addr_q;
            rd_p1_d = 1'b1;
        end
        if (rd_p2_q) begin
            tx_d   = mem_rdata;
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            S_CMD: begin
                if (rx_valid) begin
                    case (rx_byte)
                        CMD_WRITE: begin
                            cmd_rd_d = 1'b0;
                            state_d  = S_ADDR_H;
                        end
                        CMD_READ: begin
                            cmd_rd_d = 1'b1;
                            state_d  = S_ADDR_H;
                        end
                        CMD_STATUS: begin
                            tx_d    = {{(DW-1){1'b0}}, snap_q};
                            state_d = S_IGNORE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            tx_d    = '1;
                            state_d = S_IGNORE;
                        end
                    endcase
                end
            end
            S_ADDR_H: begin
                if (rx_valid) begin
                    addr_h_d = rx_byte;
                    state_d  = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (rx_valid) begin
                    addr_d  = AW'({addr_h_q, rx_byte});
                    state_d = cmd_rd_q ? S_RD : S_WR;
                    pf_d    = cmd_rd_q;
                end
            end
            S_WR: begin
                if (rx_valid) begin
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = rx_byte;
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_RD: begin
                if (tx_req) begin
                    pf_d = 1'b1;
                end
            end
            default: ;
        endcase

        // A write accepted together with frame_end still completes; read traffic is dropped
        if (frame_end) begin
            state_d = S_IDLE;
            tx_d    = '0;
            pf_d    = 1'b0;
            rd_p1_d = 1'b0;
            rd_p2_d = 1'b0;
            if (state_q != S_WR) begin
                en_d = 1'b0;
                we_d = 1'b0;
            end
        end

        // STATUS reports the error flag as it stood before this frame cleared it
        if (frame_start) begin
            state_d = S_CMD;
            tx_d    = '0;
            err_d   = 1'b0;
            snap_d  = err_q;
            pf_d    = 1'b0;
            rd_p1_d = 1'b0;
            rd_p2_d = 1'b0;
            en_d    = 1'b0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cmd_rd_q <= 1'b0;
            addr_h_q <= '0;
            addr_q   <= '0;
            tx_q     <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            snap_q   <= 1'b0;
            pf_q     <= 1'b0;
            rd_p1_q  <= 1'b0;
            rd_p2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_rd_q <= cmd_rd_d;
            addr_h_q <= addr_h_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            en_q     <= en_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            snap_q   <= snap_d;
            pf_q     <= pf_d;
            rd_p1_q  <= rd_p1_d;
            rd_p2_q  <= rd_p2_d;
        end
    end

    assign tx_byte   = tx_q;
    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign cmd_err   = err_q;

endmodule
